mmio_test_port: RTL and testbench
=================================

// Module: mmio_test_port
// PURPOSE
//  Memory-mapped responder for core data-bus stores in the test window at BASE_ADDR.
//  Buffers TXDATA words in a FIFO that drains over a valid/ready stream (console/host side).
//  Latches a HALT code and flags pass/fail, so the SoC can finish a run without bus snooping.
//  Sits beside dmem on the core's MemWrite/DataAdr/WriteData/ReadData bus.
// PARAMETERS
//  BASE_ADDR   32'h0200_0000  window base; 64-byte window, 64-byte aligned
//  FIFO_DEPTH  16             TX FIFO entries; power of 2, >= 2
//  PASS_CODE   32'd55         HALT value that signals pass
// PORTS
//  clk        in   1   system clock; all state updates on the rising edge
//  reset      in   1   synchronous, active-low reset
//  MemWrite   in   1   store strobe from core
//  DataAdr    in   32  byte address from core
//  WriteData  in   32  store data from core
//  ReadData   out  32  load data for the window; combinational from registers
//  sel        out  1   DataAdr inside window; read-mux select for top
//  out_valid  out  1   FIFO head valid
//  out_data   out  32  FIFO head word
//  out_ready  in   1   consumer accepts head when out_valid & out_ready
//  halt       out  1   sticky; a HALT write has occurred
//  pass       out  1   sticky; halt & code == PASS_CODE
//  fail       out  1   sticky; halt & code != PASS_CODE
//  halt_code  out  32  first code written to HALT
// BEHAVIOUR
//  Decode: sel = DataAdr[31:6] == BASE_ADDR[31:6]; register index = DataAdr[5:2]; DataAdr[1:0] ignored.
//  Registers (byte offsets):
//   0x00 CTRL   RW  bit0 EN (reset 1); bit1 CLR_OVF, write-1 clears OVF, reads 0
//   0x04 STATUS RO  {23'b0, OVF, HALT, FULL, EMPTY, COUNT[4:0]}; COUNT zero-extended
//   0x08 TXDATA WO  store pushes WriteData into FIFO; reads 0
//   0x0C HALT   WO  store latches halt_code and sets halt/pass/fail; reads halt_code
//   0x10-0x3C   reserved; writes ignored, reads 0. Loads have no side effects.
//  Push = MemWrite & sel & offset 0x08 & EN & !halt. Pop = out_valid & out_ready.
//  FIFO: circular buffer, wr/rd pointers wrap modulo FIFO_DEPTH; count width $clog2(FIFO_DEPTH)+1.
//   No fall-through: a push into an empty FIFO raises out_valid on the next cycle.
//   out_data stays stable while out_valid & !out_ready.
//   Push while full with no pop: word dropped, OVF set (sticky until CLR_OVF or reset).
//   Push while full with a pop in the same cycle: both happen, count unchanged, no OVF.
//   Push and pop in the same cycle when not full: count unchanged.
//   CLR_OVF and an overflowing push in the same cycle: OVF ends set (set wins).
//   EN=0: pushes ignored without setting OVF; draining continues.
//  HALT: the first HALT store sets halt=1 and halt_code=WriteData.
//   pass/fail are derived from halt_code and change in the same cycle as halt.
//   Later HALT stores are ignored (first code wins). After halt, TXDATA stores are dropped without OVF.
//   The FIFO still drains after halt.
//  Reset (reset==0 at clk edge), including mid-drain:
//   pointers and count cleared; out_valid=0, out_data=0.
//   halt/pass/fail=0, halt_code=0, OVF=0, EN=1. FIFO RAM contents don't care.
// CONFIGURATION
//  MMIO_TEST_PORT_SIM_EN defined:
//   $display("WriteData = %d", word) on every pop.
//   $finish once halt=1 and the FIFO is empty; "PASS" or "FAIL code=%d" is printed first.
//  Undefined: no system tasks; fully synthesizable; identical port behaviour.
// TESTING
//  T1 reset: reset=0 for 2 cycles -> out_valid=0, halt=0, STATUS reads 0x0000_0020 (EMPTY=1).
//  T2 stream: store 1,2,3 to 0x02000008 with out_ready=1 -> out_data 1,2,3 in order;
//     first out_valid one cycle after the first store.
//  T3 overflow: out_ready=0, 17 stores to TXDATA -> COUNT=16, FULL=1, OVF=1, 17th word lost.
//     Then CTRL=0x2 -> OVF=0.
//  T4 full + simultaneous push/pop: FIFO full, out_ready=1, store 0xAA in the same cycle
//     -> no OVF, COUNT stays 16, 0xAA is the last word out.
//  T5 halt: store 55 to 0x0200000C -> halt=1, pass=1, fail=0, halt_code=55.
//     Then store 7 to HALT -> halt_code stays 55. Then store to TXDATA -> COUNT unchanged.
//  T6 reset mid-drain: 5 words queued, out_ready toggling, reset=0 for 1 cycle
//     -> out_valid=0, COUNT=0, EN=1 next cycle.

Source files
------------

// File: rtl/mmio_test_port_if.sv
// mmio_test_port_if
//   Groups the core data-bus store/load signals and the TX drain stream of
//   the MMIO test port into one bundle.
//   master : the core / host side (drives stores, accepts stream words)
//   slave  : the test port itself
//   Signals:
//     MemWrite, DataAdr[31:0], WriteData[31:0]  core -> port
//     ReadData[31:0], sel                         port -> core
//     out_valid, out_data[31:0]                   port -> consumer
//     out_ready                                   consumer -> port
interface mmio_test_port_if;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        sel;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;

    modport master (
        output MemWrite, DataAdr, WriteData, out_ready,
        input  ReadData, sel, out_valid, out_data
    );

    modport slave (
        input  MemWrite, DataAdr, WriteData, out_ready,
        output ReadData, sel, out_valid, out_data
    );
endinterface

// File: rtl/mmio_test_port.sv
// mmio_test_port
//   Memory-mapped responder for core stores into a 64-byte test window.
//   TXDATA stores are buffered in a circular FIFO drained over a
//   valid/ready stream; a HALT store latches a completion code and raises
//   sticky halt/pass/fail flags.
//   Ports:
//     clk        system clock, rising edge
//     reset      synchronous, active-low
//     bus        mmio_test_port_if.slave (store bus + TX stream)
//     halt       sticky, a HALT store has occurred
//     pass       halt and halt_code == PASS_CODE
//     fail       halt and halt_code != PASS_CODE
//     halt_code  first code written to HALT
//   Register map (byte offset in window):
//     0x00 CTRL   bit0 EN (RW, reset 1), bit1 CLR_OVF (write-1, reads 0)
//     0x04 STATUS {23'b0, OVF, HALT, FULL, EMPTY, COUNT[4:0]}
//     0x08 TXDATA write pushes into FIFO, reads 0
//     0x0C HALT   write latches code once, reads halt_code
//   Optional build macro MMIO_TEST_PORT_SIM_EN: prints each popped word and
//   ends simulation once halted with an empty FIFO. Without it the module
//   is fully synthesizable with identical port behaviour.
module mmio_test_port #(
    parameter logic [31:0] BASE_ADDR  = 32'h0200_0000,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] PASS_CODE  = 32'd55
) (
    input  logic                   clk,
    input  logic                   reset,
    mmio_test_port_if.slave        bus,
    output logic                   halt,
    output logic                   pass,
    output logic                   fail,
    output logic [31:0]            halt_code
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [31:0]      mem [FIFO_DEPTH];
    logic             en;
    logic             ovf;

    logic             sel;
    logic [3:0]       idx;
    logic             wr_ctrl;
    logic             wr_tx;
    logic             wr_halt;
    logic             full;
    logic             empty;
    logic             push_req;
    logic             do_push;
    logic             pop;
    logic             ovf_set;
    logic [4:0]       count_5;
    logic [31:0]      status;
    logic [31:0]      rdata;
    logic [1:0]       unused_adr;

    assign unused_adr = bus.DataAdr[1:0];

    assign sel     = (bus.DataAdr[31:6] == BASE_ADDR[31:6]);
    assign idx     = bus.DataAdr[5:2];
    assign wr_ctrl = bus.MemWrite & sel & (idx == 4'd0);
    assign wr_tx   = bus.MemWrite & sel & (idx == 4'd2);
    assign wr_halt = bus.MemWrite & sel & (idx == 4'd3);

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign pop     = ~empty & bus.out_ready;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_req = wr_tx & en & ~halt;
    assign do_push  = push_req & (~full | pop);
    assign ovf_set  = push_req & full & ~pop;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            en        <= 1'b1;
            ovf       <= 1'b0;
            halt      <= 1'b0;
            halt_code <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (wr_ctrl) en <= bus.WriteData[0];
            // An overflow in the same cycle as CLR_OVF leaves OVF set.
            if (ovf_set)
                ovf <= 1'b1;
            else if (wr_ctrl && bus.WriteData[1])
                ovf <= 1'b0;
            if (wr_halt && !halt) begin
                halt      <= 1'b1;
                halt_code <= bus.WriteData;
            end
        end
    end

    // Storage has no reset; out_data is masked to zero while empty instead.
    always_ff @(posedge clk) begin
        if (reset && do_push) mem[wr_ptr] <= bus.WriteData;
    end

    assign pass = halt & (halt_code == PASS_CODE);
    assign fail = halt & (halt_code != PASS_CODE);

    assign bus.out_valid = ~empty;
    assign bus.out_data  = empty ? 32'd0 : mem[rd_ptr];
    assign bus.sel       = sel;

    assign count_5 = 5'(count);
    assign status  = {23'd0, ovf, halt, full, empty, count_5};

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (idx)
                4'd0:    rdata = {31'd0, en};
                4'd1:    rdata = status;
                4'd3:    rdata = halt_code;
                default: rdata = '0;
            endcase
        end
    end

    assign bus.ReadData = rdata;

`ifdef MMIO_TEST_PORT_SIM_EN
    always @(posedge clk) begin
        if (reset) begin
            if (pop)
                $display("WriteData = %d", bus.out_data);
            if (halt && empty) begin
                if (pass)
                    $display("PASS");
                else
                    $display("FAIL code=%d", halt_code);
                $finish;
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_mmio_test_port.sv
module tb_mmio_test_port;
    localparam int          DEPTH   = 16;
    localparam logic [31:0] BASE    = 32'h0200_0000;
    localparam logic [25:0] BASE_HI = 26'h008_0000;
    localparam logic [31:0] A_CTRL  = 32'h0200_0000;
    localparam logic [31:0] A_STAT  = 32'h0200_0004;
    localparam logic [31:0] A_TX    = 32'h0200_0008;
    localparam logic [31:0] A_HALT  = 32'h0200_000C;

    logic        clk;
    logic        reset;
    logic        halt;
    logic        pass;
    logic        fail;
    logic [31:0] halt_code;

    mmio_test_port_if bus_if();

    mmio_test_port dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_if.slave),
        .halt      (halt),
        .pass      (pass),
        .fail      (fail),
        .halt_code (halt_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: a queue of buffered words plus the flag/register state.
    logic [31:0] q[$];
    logic [31:0] popped[$];
    logic        m_en   = 1'b1;
    logic        m_ovf  = 1'b0;
    logic        m_halt = 1'b0;
    logic [31:0] m_code = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic in_window(input logic [31:0] a);
        return a[31:6] == BASE_HI;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int n;
        logic [3:0] i;
        n = q.size();
        i = a[5:2];
        if (!in_window(a)) return 32'd0;
        case (i)
            4'd0: return {31'd0, m_en};
            4'd1: return {23'd0, m_ovf, m_halt, logic'(n == DEPTH), logic'(n == 0), 5'(n)};
            4'd3: return m_code;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        int n;
        logic p;
        logic w;
        logic [3:0] i;
        if (!reset) begin
            q.delete();
            m_en = 1'b1; m_ovf = 1'b0; m_halt = 1'b0; m_code = 32'd0;
            return;
        end
        n = q.size();
        p = (n > 0) && bus_if.out_ready;
        w = bus_if.MemWrite && in_window(bus_if.DataAdr);
        i = bus_if.DataAdr[5:2];
        if (p) popped.push_back(q.pop_front());
        if (w && i == 4'd0 && bus_if.WriteData[1]) m_ovf = 1'b0;
        if (w && i == 4'd2 && m_en && !m_halt) begin
            if (n < DEPTH || p) q.push_back(bus_if.WriteData);
            else m_ovf = 1'b1;
        end
        if (w && i == 4'd0) m_en = bus_if.WriteData[0];
        if (w && i == 4'd3 && !m_halt) begin
            m_halt = 1'b1;
            m_code = bus_if.WriteData;
        end
    endtask

    // Called at a falling edge with inputs set; returns at the next falling edge.
    task automatic tick();
        #1;
        check("sel", {31'd0, bus_if.sel}, {31'd0, in_window(bus_if.DataAdr)});
        check("read_data", bus_if.ReadData, model_read(bus_if.DataAdr));
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("out_valid", {31'd0, bus_if.out_valid}, {31'd0, logic'(q.size() != 0)});
        check("out_data", bus_if.out_data, (q.size() != 0) ? q[0] : 32'd0);
        check("halt", {31'd0, halt}, {31'd0, m_halt});
        check("pass", {31'd0, pass}, {31'd0, logic'(m_halt && m_code == 32'd55)});
        check("fail", {31'd0, fail}, {31'd0, logic'(m_halt && m_code != 32'd55)});
        check("halt_code", halt_code, m_code);
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d);
        bus_if.MemWrite  = 1'b1;
        bus_if.DataAdr   = a;
        bus_if.WriteData = d;
        tick();
        bus_if.MemWrite  = 1'b0;
        bus_if.DataAdr   = A_STAT;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus_if.DataAdr = a;
        #1;
        check(tag, bus_if.ReadData, exp);
        bus_if.DataAdr = A_STAT;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        int r;
        reset            = 1'b0;
        bus_if.MemWrite  = 1'b0;
        bus_if.DataAdr   = A_STAT;
        bus_if.WriteData = 32'd0;
        bus_if.out_ready = 1'b0;
        @(negedge clk);

        // T1 reset
        tick(); tick();
        reset = 1'b1;
        check("t1_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check("t1_halt", {31'd0, halt}, 32'd0);
        peek("t1_status", A_STAT, 32'h0000_0020);
        peek("t1_ctrl", A_CTRL, 32'h0000_0001);

        // T2 stream
        bus_if.out_ready = 1'b1;
        popped.delete();
        write(A_TX, 32'd1);
        check("t2_first_valid", {31'd0, bus_if.out_valid}, 32'd1);
        check("t2_first_data", bus_if.out_data, 32'd1);
        write(A_TX, 32'd2);
        write(A_TX, 32'd3);
        idle(3);
        check("t2_pop_count", popped.size(), 32'd3);
        if (popped.size() == 3) begin
            check("t2_word0", popped[0], 32'd1);
            check("t2_word1", popped[1], 32'd2);
            check("t2_word2", popped[2], 32'd3);
        end

        // T3 overflow
        bus_if.out_ready = 1'b0;
        for (int i = 0; i < 17; i++) write(A_TX, 32'h100 + i);
        peek("t3_status_ovf", A_STAT, 32'h0000_0150);
        check("t3_head", bus_if.out_data, 32'h100);
        write(A_CTRL, 32'h2);
        peek("t3_status_clr", A_STAT, 32'h0000_0050);
        peek("t3_ctrl_en0", A_CTRL, 32'h0000_0000);
        write(A_CTRL, 32'h1);

        // T4 full with simultaneous push and pop
        popped.delete();
        bus_if.out_ready = 1'b1;
        write(A_TX, 32'hAA);
        peek("t4_status", A_STAT, 32'h0000_0050);
        idle(16);
        check("t4_pop_count", popped.size(), 32'd17);
        if (popped.size() == 17) begin
            check("t4_first", popped[0], 32'h100);
            check("t4_last", popped[16], 32'hAA);
        end

        // T5 halt
        write(A_HALT, 32'd55);
        check("t5_halt", {31'd0, halt}, 32'd1);
        check("t5_pass", {31'd0, pass}, 32'd1);
        check("t5_fail", {31'd0, fail}, 32'd0);
        check("t5_code", halt_code, 32'd55);
        write(A_HALT, 32'd7);
        check("t5_code_kept", halt_code, 32'd55);
        bus_if.out_ready = 1'b0;
        write(A_TX, 32'd9);
        peek("t5_status", A_STAT, 32'h0000_00A0);
        peek("t5_halt_read", A_HALT, 32'd55);

        pulse_reset();
        write(A_HALT, 32'd9);
        check("t5_fail_code", {31'd0, fail}, 32'd1);
        check("t5_fail_pass", {31'd0, pass}, 32'd0);

        // T6 reset mid-drain
        pulse_reset();
        for (int i = 0; i < 5; i++) write(A_TX, 32'h500 + i);
        for (int i = 0; i < 4; i++) begin
            bus_if.out_ready = logic'(i % 2);
            tick();
        end
        pulse_reset();
        check("t6_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check("t6_out_data", bus_if.out_data, 32'd0);
        peek("t6_status", A_STAT, 32'h0000_0020);
        peek("t6_ctrl", A_CTRL, 32'h0000_0001);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 63) != 0);
            if (c % 100 == 0) r = $urandom_range(0, 3);
            bus_if.out_ready = ($urandom_range(0, 3) < r);
            bus_if.MemWrite  = logic'($urandom_range(0, 1));
            bus_if.WriteData = $urandom;
            case ($urandom_range(0, 15))
                0, 1, 2, 3, 4, 5, 6, 7, 8, 9: bus_if.DataAdr = A_TX;
                10, 11: begin
                    bus_if.DataAdr = A_CTRL;
                    if ($urandom_range(0, 3) != 0) bus_if.WriteData[0] = 1'b1;
                end
                12: bus_if.DataAdr = A_STAT;
                13: bus_if.DataAdr = BASE + 32'($urandom_range(4, 15) * 4) + 32'($urandom_range(0, 3));
                14: bus_if.DataAdr = BASE ^ (32'd1 << $urandom_range(6, 31)) | 32'h8;
                default: begin
                    if ($urandom_range(0, 20) == 0) begin
                        bus_if.DataAdr = A_HALT;
                        if ($urandom_range(0, 1) == 1) bus_if.WriteData = 32'd55;
                    end else begin
                        bus_if.DataAdr = A_TX + 32'($urandom_range(0, 3));
                    end
                end
            endcase
            tick();
        end
        reset = 1'b1;
        bus_if.MemWrite  = 1'b0;
        bus_if.out_ready = 1'b1;
        idle(DEPTH + 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
